// File: rtl/dbg_jtag_tap_if.sv
// Signal bundle between the JTAG TAP and the downstream DMI access stage.
// The TAP drives the state strobes and instruction selects; the DMI stage returns its error and serial output.
interface dbg_jtag_tap_if;
    logic       test_logic_reset_o;
    logic       shift_dr_o;
    logic       update_dr_o;
    logic       capture_dr_o;
    logic       dmi_access_o;
    logic       dtmcs_select_o;
    logic       dmi_reset_o;
    logic [1:0] dmi_error_i;
    logic       dmi_tdi_o;
    logic       dmi_tdo_i;

    modport master (
        output test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o,
        output dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o,
        input  dmi_error_i, dmi_tdo_i
    );

    modport slave (
        input  test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o,
        input  dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o,
        output dmi_error_i, dmi_tdo_i
    );
endinterface

// File: rtl/dbg_jtag_tap.sv
// IEEE 1149.1 TAP controller for the RISC-V debug transport: state decode, IR,
// IDCODE/BYPASS/DTMCS data registers and the TDO mux toward the pads.
module dbg_jtag_tap #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001
) (
    input  logic           tck_i,
    input  logic           trst_ni,
    input  logic           tms_i,
    input  logic           td_i,
    output logic           td_o,
    output logic           tdo_oe_o,
    input  logic           testmode_i,
    dbg_jtag_tap_if.master dmi
);
    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle,
        SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
        SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } tap_state_e;

    localparam logic [IrLength-1:0] IrIdcode  = IrLength'('h01);
    localparam logic [IrLength-1:0] IrDtmcs   = IrLength'('h10);
    localparam logic [IrLength-1:0] IrDmi     = IrLength'('h11);
    localparam logic [IrLength-1:0] IrCapture = IrLength'('b00101);

    tap_state_e          r_state;
    tap_state_e          w_state_next;
    logic [IrLength-1:0] r_ir_shift;
    logic [IrLength-1:0] r_ir;
    logic [31:0]         r_idcode;
    logic [31:0]         r_dtmcs;
    logic                r_bypass;
    logic                r_tdo_n, r_oe_n, r_tdo_p, r_oe_p;

    logic                w_tlr, w_capture_dr, w_shift_dr, w_update_dr;
    logic                w_sel_idcode, w_sel_dtmcs, w_sel_dmi, w_sel_bypass;
    logic                w_tdo, w_tdo_oe;
    logic [31:0]         w_dtmcs_capture;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_state <= TestLogicReset;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tlr        = 1'b0;
        w_capture_dr = 1'b0;
        w_shift_dr   = 1'b0;
        w_update_dr  = 1'b0;
        unique case (r_state)
            TestLogicReset: begin
                w_tlr = 1'b1;
                if (!tms_i) w_state_next = RunTestIdle;
            end
            RunTestIdle:  if (tms_i) w_state_next = SelectDrScan;
            SelectDrScan: w_state_next = tms_i ? SelectIrScan : CaptureDr;
            CaptureDr: begin
                w_capture_dr = 1'b1;
                w_state_next = tms_i ? Exit1Dr : ShiftDr;
            end
            ShiftDr: begin
                w_shift_dr = 1'b1;
                if (tms_i) w_state_next = Exit1Dr;
            end
            Exit1Dr:      w_state_next = tms_i ? UpdateDr : PauseDr;
            PauseDr:      if (tms_i) w_state_next = Exit2Dr;
            Exit2Dr:      w_state_next = tms_i ? UpdateDr : ShiftDr;
            UpdateDr: begin
                w_update_dr  = 1'b1;
                w_state_next = tms_i ? SelectDrScan : RunTestIdle;
            end
            SelectIrScan: w_state_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:    w_state_next = tms_i ? Exit1Ir : ShiftIr;
            ShiftIr:      if (tms_i) w_state_next = Exit1Ir;
            Exit1Ir:      w_state_next = tms_i ? UpdateIr : PauseIr;
            PauseIr:      if (tms_i) w_state_next = Exit2Ir;
            Exit2Ir:      w_state_next = tms_i ? UpdateIr : ShiftIr;
            UpdateIr:     w_state_next = tms_i ? SelectDrScan : RunTestIdle;
        endcase
    end

    // IR is forced to IDCODE on the edge that enters TLR so it already reads IDCODE while in TLR.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir_shift <= '0;
            r_ir       <= IrIdcode;
        end else begin
            if (r_state == CaptureIr)    r_ir_shift <= IrCapture;
            else if (r_state == ShiftIr) r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};

            if (w_state_next == TestLogicReset) r_ir <= IrIdcode;
            else if (r_state == UpdateIr)       r_ir <= r_ir_shift;
        end
    end

    assign w_sel_idcode    = (r_ir == IrIdcode);
    assign w_sel_dtmcs     = (r_ir == IrDtmcs);
    assign w_sel_dmi       = (r_ir == IrDmi);
    assign w_sel_bypass    = !(w_sel_idcode || w_sel_dtmcs || w_sel_dmi);
    assign w_dtmcs_capture = {17'd0, 3'd1, dmi.dmi_error_i, 6'd7, 4'd1};

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_idcode <= '0;
            r_dtmcs  <= '0;
            r_bypass <= 1'b0;
        end else if (w_capture_dr) begin
            if (w_sel_idcode) r_idcode <= IdcodeValue;
            if (w_sel_dtmcs)  r_dtmcs  <= w_dtmcs_capture;
            if (w_sel_bypass) r_bypass <= 1'b0;
        end else if (w_shift_dr) begin
            if (w_sel_idcode) r_idcode <= {td_i, r_idcode[31:1]};
            if (w_sel_dtmcs)  r_dtmcs  <= {td_i, r_dtmcs[31:1]};
            if (w_sel_bypass) r_bypass <= td_i;
        end
    end

    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_oe = (r_state == ShiftIr) || (r_state == ShiftDr);
        if (r_state == ShiftIr) begin
            w_tdo = r_ir_shift[0];
        end else if (r_state == ShiftDr) begin
            if (w_sel_dmi)         w_tdo = dmi.dmi_tdo_i;
            else if (w_sel_idcode) w_tdo = r_idcode[0];
            else if (w_sel_dtmcs)  w_tdo = r_dtmcs[0];
            else                   w_tdo = r_bypass;
        end
    end

    // Scan mode needs TDO on the rising edge; two flop pairs avoid muxing the clock itself.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_tdo_n <= 1'b0;
            r_oe_n  <= 1'b0;
        end else begin
            r_tdo_n <= w_tdo;
            r_oe_n  <= w_tdo_oe;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_tdo_p <= 1'b0;
            r_oe_p  <= 1'b0;
        end else begin
            r_tdo_p <= w_tdo;
            r_oe_p  <= w_tdo_oe;
        end
    end

    assign td_o     = testmode_i ? r_tdo_p : r_tdo_n;
    assign tdo_oe_o = testmode_i ? r_oe_p  : r_oe_n;

    assign dmi.test_logic_reset_o = w_tlr;
    assign dmi.shift_dr_o         = w_shift_dr;
    assign dmi.update_dr_o        = w_update_dr;
    assign dmi.capture_dr_o       = w_capture_dr;
    assign dmi.dmi_access_o       = w_sel_dmi;
    assign dmi.dtmcs_select_o     = w_sel_dtmcs;
    assign dmi.dmi_reset_o        = w_update_dr && w_sel_dtmcs && r_dtmcs[16];
    assign dmi.dmi_tdi_o          = td_i;
endmodule

// File: tb/tb_dbg_jtag_tap.sv
// Self-checking bench for dbg_jtag_tap: directed scans plus random TMS/TDI walks,
// compared every cycle against a table-driven TAP model.
module tb_dbg_jtag_tap;
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
    localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    logic tck      = 1'b0;
    logic trst_ni  = 1'b0;
    logic tms      = 1'b1;
    logic tdi      = 1'b0;
    logic testmode = 1'b0;
    logic td_o, tdo_oe;

    int n_chk = 0;
    int n_err = 0;
    int n_pulse = 0;
    int n_upd = 0;

    int          m_st  = TLR;
    logic [4:0]  m_ir  = 5'h01;
    logic [4:0]  m_irsh = '0;
    logic [31:0] m_dr  = '0;
    int          m_len = 1;

    dbg_jtag_tap_if u_if ();

    dbg_jtag_tap #(.IrLength(5), .IdcodeValue(32'h00000001)) dut (
        .tck_i      (tck),
        .trst_ni    (trst_ni),
        .tms_i      (tms),
        .td_i       (tdi),
        .td_o       (td_o),
        .tdo_oe_o   (tdo_oe),
        .testmode_i (testmode),
        .dmi        (u_if.master)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = TLR; m_ir = 5'h01; m_irsh = '0; m_dr = '0; m_len = 1;
    endtask

    task automatic m_step(input logic t_ms, input logic t_di);
        case (m_st)
            CDR: begin
                case (m_ir)
                    5'h01:   begin m_dr = 32'h00000001; m_len = 32; end
                    5'h10:   begin
                        m_dr  = 32'd1 + (32'd7 << 4) + (32'(u_if.dmi_error_i) << 10) + (32'd1 << 12);
                        m_len = 32;
                    end
                    5'h11:   m_len = 0;
                    default: begin m_dr = 32'd0; m_len = 1; end
                endcase
            end
            SHDR: if (m_len > 0) m_dr = (m_dr >> 1) | (32'(t_di) << (m_len - 1));
            CIR:  m_irsh = 5'b00101;
            SHIR: m_irsh = {t_di, m_irsh[4:1]};
            UIR:  m_ir = m_irsh;
            default: ;
        endcase
        m_st = t_ms ? nxt1[m_st] : nxt0[m_st];
        if (m_st == TLR) m_ir = 5'h01;
    endtask

    task automatic check_outputs();
        chk("tlr",      u_if.test_logic_reset_o, 32'(m_st == TLR));
        chk("shift_dr", u_if.shift_dr_o,         32'(m_st == SHDR));
        chk("capture",  u_if.capture_dr_o,       32'(m_st == CDR));
        chk("update",   u_if.update_dr_o,        32'(m_st == UDR));
        chk("dmi_acc",  u_if.dmi_access_o,       32'(m_ir == 5'h11));
        chk("dtmcs_sel",u_if.dtmcs_select_o,     32'(m_ir == 5'h10));
        chk("dmi_rst",  u_if.dmi_reset_o,        32'(m_st == UDR && m_ir == 5'h10 && m_dr[16]));
        chk("dmi_tdi",  u_if.dmi_tdi_o,          32'(tdi));
        chk("tdo_oe",   tdo_oe,                  32'(m_st == SHDR || m_st == SHIR));
        if (m_st == SHIR)      chk("tdo_ir", td_o, 32'(m_irsh[0]));
        else if (m_st == SHDR) chk("tdo_dr", td_o, 32'((m_len == 0) ? u_if.dmi_tdo_i : m_dr[0]));
        if (u_if.dmi_reset_o) n_pulse++;
        if (u_if.update_dr_o) n_upd++;
    endtask

    task automatic tick(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        u_if.dmi_tdo_i = 1'($urandom);
        @(posedge tck);
        m_step(t_ms, t_di);
        @(negedge tck);
        #1;
        check_outputs();
    endtask

    task automatic scan_ir(input logic [4:0] code, output logic [4:0] dout);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) begin
            dout[i] = td_o;
            tick(i == 4, code[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) begin
            dout[i] = td_o;
            tick(i == n - 1, din[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [4:0]  irout;
        logic [4:0]  code;
        u_if.dmi_error_i = 2'b00;
        u_if.dmi_tdo_i   = 1'b0;
        m_reset();
        #2;
        chk("rst_tlr",   u_if.test_logic_reset_o, 1);
        chk("rst_upd",   u_if.update_dr_o, 0);
        chk("rst_dmiacc",u_if.dmi_access_o, 0);
        chk("rst_oe",    tdo_oe, 0);
        chk("rst_tdo",   td_o, 0);
        @(negedge tck); #1;
        trst_ni = 1'b1;
        tick(0, 0);

        scan_dr(32'h0, 32, w);
        chk("idcode_word", w, 32'h00000001);

        u_if.dmi_error_i = 2'b11;
        scan_ir(5'h10, irout);
        chk("ir_capture", 32'(irout), 32'h05);
        chk("dtmcs_sel_on", u_if.dtmcs_select_o, 1);
        scan_dr(32'h0, 32, w);
        chk("dtmcs_word", w, 32'h00001C71);

        n_pulse = 0;
        scan_dr(32'h00010000, 32, w);
        chk("dmireset_one", n_pulse, 1);
        n_pulse = 0;
        scan_dr(32'h00020000, 32, w);
        chk("hardreset_none", n_pulse, 0);

        scan_ir(5'h1F, irout);
        scan_dr(32'hD, 4, w);
        chk("bypass_pat", w, 32'hA);

        scan_ir(5'h11, irout);
        chk("dmi_acc_on", u_if.dmi_access_o, 1);
        scan_dr($urandom, 32, w);

        tick(1, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        chk("tlr_after5", u_if.test_logic_reset_o, 1);
        chk("dmi_acc_tlr", u_if.dmi_access_o, 0);
        tick(0, 0);
        scan_dr(32'h0, 32, w);
        chk("idcode_after_tlr", w, 32'h00000001);

        for (int it = 0; it < 40; it++) begin
            u_if.dmi_error_i = 2'($urandom);
            case ($urandom_range(0, 4))
                0:       code = 5'h01;
                1:       code = 5'h10;
                2:       code = 5'h11;
                3:       code = 5'h1F;
                default: code = 5'($urandom);
            endcase
            scan_ir(code, irout);
            chk("ir_capture_rnd", 32'(irout), 32'h05);
            scan_dr($urandom, 32, w);
            if (code == 5'h01) chk("idcode_rnd", w, 32'h00000001);
            for (int k = 0; k < 40; k++) tick($urandom_range(0, 3) == 0, 1'($urandom));
            for (int k = 0; k < 5; k++) tick(1, 1'($urandom));
            tick(0, 0);
        end

        scan_ir(5'h10, irout);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 6; i++) tick(0, 1'($urandom));
        #1;
        trst_ni = 1'b0;
        #1;
        chk("arst_tlr",   u_if.test_logic_reset_o, 1);
        chk("arst_shift", u_if.shift_dr_o, 0);
        chk("arst_dtmcs", u_if.dtmcs_select_o, 0);
        chk("arst_oe",    tdo_oe, 0);
        chk("arst_tdo",   td_o, 0);
        m_reset();
        @(negedge tck); #1;
        trst_ni = 1'b1;
        n_upd = 0;
        tick(1, 0); tick(1, 0); tick(0, 0);
        chk("no_update_after_rst", n_upd, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dbg_jtag_tap.md
# dbg_jtag_tap

IEEE 1149.1 TAP controller for the RISC-V debug transport module. Sits directly upstream of the DMI access stage. It decodes TMS/TDI from the pads into TAP state strobes, holds the instruction register, and implements the IDCODE, BYPASS and DTMCS data registers. The DMI shift register lives in the downstream DMI stage; this block only hands out the shift strobes and muxes that stage's serial output onto TDO.

## Interface
- IrLength, 5: instruction register width in bits.
- IdcodeValue, 32'h00000001: value loaded into IDCODE on Capture-DR; bit 0 must be 1.

Ports:
- tck_i  in  1  JTAG test clock; all state advances on posedge.
- trst_ni  in  1  reset, asynchronous, active-low.
- tms_i  in  1  test mode select.
- td_i  in  1  test data in.
- td_o  out  1  test data out; registered on negedge tck_i.
- tdo_oe_o  out  1  TDO output enable; registered on negedge tck_i.
- testmode_i  in  1  scan mode; when 1, the TDO/OE flops clock on posedge tck_i.
- test_logic_reset_o  out  1  TAP state is Test-Logic-Reset.
- shift_dr_o  out  1  TAP state is Shift-DR.
- update_dr_o  out  1  TAP state is Update-DR.
- capture_dr_o  out  1  TAP state is Capture-DR.
- dmi_access_o  out  1  IR == DMIACCESS.
- dtmcs_select_o  out  1  IR == DTMCS.
- dmi_reset_o  out  1  single-cycle dmireset strobe.
- dmi_error_i  in  2  sticky DMI error, reported in dtmcs.dmistat.
- dmi_tdi_o  out  1  td_i passed through to the DMI shift register.
- dmi_tdo_i  in  1  LSB of the DMI shift register.

## Operation
- TAP FSM: 16 standard states, reset state Test-Logic-Reset (TLR). Transitions follow 1149.1 exactly:
  - TLR -(0)-> Run-Test/Idle.
  - RTI -(1)-> Select-DR.
  - Select-DR -(1)-> Select-IR, -(0)-> Capture-DR.
  - Select-IR -(1)-> TLR, -(0)-> Capture-IR.
  - Capture -(0)-> Shift, -(1)-> Exit1.
  - Shift -(1)-> Exit1.
  - Exit1 -(0)-> Pause, -(1)-> Update.
  - Pause -(1)-> Exit2.
  - Exit2 -(0)-> Shift, -(1)-> Update.
  - Update -(1)-> Select-DR, -(0)-> RTI.
  - Any state not listed holds on the other TMS value.
- All state strobes are combinational decodes of the registered state.
- IR shift register: Capture-IR loads 'b00101. Shift-IR shifts right with td_i entering the MSB. Update-IR copies it into the IR.
- IR reset value is IDCODE (0x01), both on trst_ni and whenever the FSM is in TLR.
- Instruction decode:
  - 0x01 IDCODE.
  - 0x10 DTMCS.
  - 0x11 DMIACCESS.
  - 0x00, 0x1F and every other code select BYPASS.
- IDCODE DR: 32 bits. Capture loads IdcodeValue; Shift shifts right, td_i into the MSB.
- BYPASS DR: 1 bit. Capture loads 0; Shift loads td_i.
- DTMCS DR: 32 bits. Capture loads the following; all other bits are 0:
  - [3:0] version = 1.
  - [9:4] abits = 7.
  - [11:10] dmistat = dmi_error_i.
  - [14:12] idle = 1.
- DTMCS Shift shifts right, td_i into the MSB.
- dmi_reset_o = update_dr_o & dtmcs_select_o & dtmcs_shift[16]. Bit 17 (dmihardreset) is ignored.
- DR shift registers capture and shift only when their instruction is selected.
- TDO mux (computed before the negedge flop):
  - Shift-IR: IR shift register [0].
  - Shift-DR, DMIACCESS: dmi_tdo_i.
  - Shift-DR, IDCODE or DTMCS: that register's [0].
  - Shift-DR, otherwise: bypass bit.
- tdo_oe_o = 1 only in Shift-IR or Shift-DR.

## Timing
- trst_ni low, asynchronously:
  - FSM to TLR, IR = 0x01, all shift registers = 0, td_o = 0, tdo_oe_o = 0.
  - Strobes: test_logic_reset_o = 1, dmi_access_o = 0, dtmcs_select_o = 0, dmi_reset_o = 0, all others 0.
- Five consecutive TMS=1 posedges reach TLR from any state, with no trst_ni needed.
- Each Capture/Update strobe lasts exactly one tck cycle. Shift-DR strobes once per bit.
- td_o changes on the falling edge after the posedge that entered or advanced the Shift state. Data is valid for the following rising edge at the tester.
- DMI stage interface:
  - dmi_access_o and dtmcs_select_o change only on the posedge leaving Update-IR.
  - They are stable throughout every DR scan.
- Entering TLR mid-scan discards the scan; the IR returns to IDCODE.
- trst_ni asserted mid-scan aborts immediately; no Update strobe is issued.

## Test plan
- Reset, then TMS=0 and Capture-DR/Shift-DR 32 bits with td_i=0: td_o serialises 0x00000001 LSB first; tdo_oe_o is 1 only during the shifts.
- Load IR=0x10 with dmi_error_i=2'b11, then scan DR: shifted-out word = 0x00001C71; dtmcs_select_o=1.
- With IR=0x10, shift in 0x00010000 and pass through Update-DR: dmi_reset_o is high for exactly one tck; shifting 0x00020000 gives no pulse.
- Load IR=0x1F and shift pattern 1011 through: td_o reproduces the pattern delayed one bit, first bit out 0. Load IR=0x11: dmi_access_o=1 and td_o follows dmi_tdo_i.
- Shift-IR the first IrLength bits after Capture-IR: td_o = 1,0,1,0,0. Then drive TMS=1 ×5 from Pause-DR: FSM reaches TLR and IR reads back as IDCODE.
- Assert trst_ni mid Shift-DR: all outputs reach their reset values asynchronously; no update_dr_o pulse follows.
